// File: rtl/comb_filter_feedforward.sv
// Feed-forward comb, y[n] = sat16(x[n] + (x[n-DELAY] >>> GAIN_SHIFT)); registered output, 1-cycle latency.
// No backpressure: a new sample is accepted on every clk edge, there is no enable or handshake.
module comb_filter_feedforward #(
  parameter int DELAY      = 256,
  parameter int GAIN_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] audio_in,
  output logic signed [15:0] audio_out
);

  localparam int PTR_W = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DELAY - 1);

  logic signed [15:0] delay_mem [DELAY];
  logic [PTR_W-1:0]   wr_ptr;
  logic               filled;

  logic signed [15:0] delayed_dat;
  logic signed [15:0] scaled_dat;
  logic signed [16:0] sum_dat;
  logic signed [15:0] sat_dat;

  // The slot under wr_ptr still holds x[n-DELAY]; it is overwritten on this same edge.
  always_comb begin
    delayed_dat = delay_mem[wr_ptr];
    scaled_dat  = '0;
    if (filled) begin
      scaled_dat = delayed_dat >>> GAIN_SHIFT;
    end
    sum_dat = {audio_in[15], audio_in} + {scaled_dat[15], scaled_dat};
    sat_dat = sum_dat[15:0];
    if (sum_dat[16] != sum_dat[15]) begin
      sat_dat = sum_dat[16] ? 16'sh8000 : 16'sh7fff;
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr    <= '0;
      filled    <= 1'b0;
      audio_out <= '0;
    end else begin
      audio_out <= sat_dat;
      if (wr_ptr == PTR_LAST) begin
        wr_ptr <= '0;
        filled <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // History RAM is never cleared; the fill flag masks stale contents instead.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      delay_mem[wr_ptr] <= audio_in;
    end
  end

endmodule

// File: tb/tb_comb_filter_feedforward.sv
// Directed bench: DELAY=4 vector table plus reset sequences, and a DELAY=256 sine run.
module tb_comb_filter_feedforward;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] din_a;
  logic signed [15:0] dout_a;
  logic signed [15:0] din_b;
  logic signed [15:0] dout_b;

  comb_filter_feedforward #(.DELAY(4), .GAIN_SHIFT(1)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .audio_in  (din_a),
    .audio_out (dout_a)
  );

  comb_filter_feedforward dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .audio_in  (din_b),
    .audio_out (dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst_before;
    logic [15:0] din;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   xs [2048];

  task automatic check(string nm, int idx, logic [15:0] got, logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, got, exp);
  endtask

  task automatic add(bit r, logic [15:0] d, logic [15:0] e, string nm);
    vec_t v;
    v.rst_before = r;
    v.din        = d;
    v.exp        = e;
    v.name       = nm;
    vecs.push_back(v);
  endtask

  // Reset asserted between edges; output must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_async_a", 0, dout_a, 16'h0000);
    check("rst_async_b", 0, dout_b, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_a", 0, dout_a, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  function automatic int sat16(int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  initial begin
    rst_n = 1'b1;
    din_a = '0;
    din_b = '0;

    // Impulse 0x4000
    add(1, 16'h4000, 16'h4000, "impulse");
    for (int i = 1; i < 9; i++) add(0, 16'h0000, (i == 4) ? 16'h2000 : 16'h0000, "impulse");
    // Constant 0x1000
    add(1, 16'h1000, 16'h1000, "const");
    for (int i = 1; i < 7; i++) add(0, 16'h1000, (i < 4) ? 16'h1000 : 16'h1800, "const");
    // Positive saturation
    add(1, 16'h7000, 16'h7000, "sat_pos");
    for (int i = 1; i < 7; i++) add(0, 16'h7000, (i < 4) ? 16'h7000 : 16'h7fff, "sat_pos");
    // Negative saturation
    add(1, 16'h9000, 16'h9000, "sat_neg");
    for (int i = 1; i < 7; i++) add(0, 16'h9000, (i < 4) ? 16'h9000 : 16'h8000, "sat_neg");
    // Impulse of -1: arithmetic shift keeps -1
    add(1, 16'hffff, 16'hffff, "neg_imp");
    for (int i = 1; i < 7; i++) add(0, 16'h0000, (i == 4) ? 16'hffff : 16'h0000, "neg_imp");
    // Ramp 0x100*(n+1) across two pointer wraps
    add(1, 16'h0100, 16'h0100, "ramp");
    add(0, 16'h0200, 16'h0200, "ramp");
    add(0, 16'h0300, 16'h0300, "ramp");
    add(0, 16'h0400, 16'h0400, "ramp");
    add(0, 16'h0500, 16'h0580, "ramp");
    add(0, 16'h0600, 16'h0700, "ramp");
    add(0, 16'h0700, 16'h0880, "ramp");
    add(0, 16'h0800, 16'h0a00, "ramp");
    add(0, 16'h0900, 16'h0b80, "ramp");
    add(0, 16'h0a00, 16'h0d00, "ramp");
    add(0, 16'h0b00, 16'h0e80, "ramp");
    add(0, 16'h0c00, 16'h1000, "ramp");
    // Odd negative delayed value: -3 >>> 1 = -2
    add(1, 16'hfffd, 16'hfffd, "neg_odd");
    for (int i = 1; i < 6; i++) add(0, 16'h0000, (i == 4) ? 16'hfffe : 16'h0000, "neg_odd");

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) do_reset();
      din_a = vecs[i].din;
      @(posedge clk);
      #1;
      check(vecs[i].name, i, dout_a, vecs[i].exp);
    end

    // Reset mid-stream, then behaviour must match power-up
    do_reset();
    din_a = 16'h1000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("mid_pre", i, dout_a, (i < 4) ? 16'h1000 : 16'h1800);
    end
    #2;
    rst_n = 1'b1;
    #1;
    check("mid_async", 0, dout_a, 16'h0000);
    din_a = 16'h7777;
    repeat (3) @(posedge clk);
    #1;
    check("mid_hold", 0, dout_a, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    din_a = 16'h1000;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      check("mid_post", i, dout_a, (i < 4) ? 16'h1000 : 16'h1800);
    end

    // DELAY=256: one 2048-sample sine period at 0x4000 amplitude
    for (int n = 0; n < 2048; n++) xs[n] = $rtoi(16384.0 * $sin(2.0 * 3.14159265358979 * n / 2048.0));
    do_reset();
    for (int n = 0; n < 2048; n++) begin
      int e;
      din_b = 16'(xs[n]);
      e = (n < 256) ? xs[n] : sat16(xs[n] + (xs[n-256] >>> 1));
      @(posedge clk);
      #1;
      check("sine", n, dout_b, 16'(e));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
